// File: rtl/prog_delay_line.sv
// prog_delay_line: programmable delay line for CHANNELS parallel lanes.
// Samples go into a circular buffer of MAX_DEPTH entries per lane. The
// output is the sample accepted D accepts earlier, one clock after the
// accept. D can be reloaded at run time; a reload flushes the fill count
// without touching the buffer or the write pointer.
// Optional feature: define PROG_DELAY_LINE_OCCUPANCY_EN to add the o_fill
// output (registered fill count).
module prog_delay_line #(
    parameter int WIDTH       = 10,
    parameter int CHANNELS    = 1,
    parameter int MAX_DEPTH   = 64,
    parameter int RESET_DELAY = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               i_valid,
    input  logic [CHANNELS*WIDTH-1:0]          i_data,
    input  logic                               i_delay_we,
    input  logic [$clog2(MAX_DEPTH+1)-1:0]     i_delay,
    output logic                               o_valid,
    output logic [CHANNELS*WIDTH-1:0]          o_data,
    output logic                               o_clamped
`ifdef PROG_DELAY_LINE_OCCUPANCY_EN
    ,
    output logic [$clog2(MAX_DEPTH+1)-1:0]     o_fill
`endif
);

    // Width of delay / fill values (must hold 0..MAX_DEPTH inclusive).
    localparam int FW = $clog2(MAX_DEPTH + 1);
    // Width of a buffer address; a single-entry buffer still needs one bit.
    localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    // Scratch width for read-address arithmetic, wide enough for wp + MAX_DEPTH.
    localparam int XW = ((AW > FW) ? AW : FW) + 1;

    localparam logic [FW-1:0] MAX_D  = FW'(MAX_DEPTH);
    localparam logic [FW-1:0] RST_D  = FW'(RESET_DELAY);
    localparam logic [AW-1:0] LAST_A = AW'(MAX_DEPTH - 1);
    localparam logic [XW-1:0] DEPTH_X = XW'(MAX_DEPTH);

    // EMPTY: nothing accepted since flush; FILLING: 0 < fill < D;
    // RUN: fill >= D, every accept produces an output until the next flush.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        RUN     = 2'd2
    } mode_t;

    mode_t           state_reg, state_next, state_eff;
    logic [AW-1:0]   wp_reg, wp_next;
    logic [FW-1:0]   fill_reg, fill_next, fill_eff;
    logic [FW-1:0]   delay_reg, delay_next;
    logic            clamped_reg, clamped_next;
    logic            valid_reg;
    logic            req_over;
    logic            out_fire;
    logic [XW-1:0]   wp_x, d_x, rd_x;
    logic [AW-1:0]   rd_addr;
    logic [FW:0]     fill_inc;

    // Delay load, clamp flag and the flush-adjusted view of fill/mode.
    // A load takes effect on the same cycle, so an accept arriving with it
    // is counted under the new delay from an empty line.
    always_comb begin
        req_over     = (i_delay > MAX_D);
        delay_next   = delay_reg;
        clamped_next = clamped_reg;
        if (i_delay_we) begin
            delay_next = req_over ? MAX_D : i_delay;
            if (req_over) begin
                clamped_next = 1'b1;
            end
        end
        fill_eff  = i_delay_we ? '0 : fill_reg;
        state_eff = i_delay_we ? EMPTY : state_reg;
    end

    // Fill counter (saturating) and write pointer (wraps at MAX_DEPTH-1).
    always_comb begin
        fill_next = fill_eff;
        if (i_valid && (fill_eff != MAX_D)) begin
            fill_next = fill_eff + FW'(1);
        end
        wp_next = wp_reg;
        if (i_valid) begin
            wp_next = (wp_reg == LAST_A) ? '0 : wp_reg + AW'(1);
        end
    end

    // Mode FSM next state: accepts advance it, RUN holds until a flush.
    always_comb begin
        state_next = state_eff;
        fill_inc   = {1'b0, fill_eff} + (FW+1)'(1);
        if (i_valid) begin
            case (state_eff)
                EMPTY:   state_next = (delay_next <= FW'(1)) ? RUN : FILLING;
                FILLING: state_next = (fill_inc >= {1'b0, delay_next}) ? RUN : FILLING;
                RUN:     state_next = RUN;
                default: state_next = EMPTY;
            endcase
        end
    end

    // An accept produces an output when the line already holds D samples;
    // D=0 is a pure one-register pass-through.
    always_comb begin
        out_fire = i_valid && ((delay_next == '0) || (state_eff == RUN));
    end

    // Read address: the entry written D accepts ago, i.e. wp - D modulo
    // MAX_DEPTH. With D=MAX_DEPTH this is wp itself, read before overwrite.
    always_comb begin
        wp_x = XW'(wp_reg);
        d_x  = XW'(delay_next);
        if (wp_x >= d_x) begin
            rd_x = wp_x - d_x;
        end else begin
            rd_x = wp_x + DEPTH_X - d_x;
        end
        rd_addr = rd_x[AW-1:0];
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= EMPTY;
            wp_reg      <= '0;
            fill_reg    <= '0;
            delay_reg   <= RST_D;
            clamped_reg <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wp_reg      <= wp_next;
            fill_reg    <= fill_next;
            delay_reg   <= delay_next;
            clamped_reg <= clamped_next;
            valid_reg   <= out_fire;
        end
    end

    assign o_valid   = valid_reg;
    assign o_clamped = clamped_reg;

`ifdef PROG_DELAY_LINE_OCCUPANCY_EN
    assign o_fill = fill_reg;
`endif

    // One independent buffer and output register per lane; all lanes share
    // the pointer, delay and valid, so they are delayed identically.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        logic [WIDTH-1:0] mem [0:MAX_DEPTH-1];
        logic [WIDTH-1:0] lane_in;
        logic [WIDTH-1:0] dout_reg;

        assign lane_in = i_data[gi*WIDTH +: WIDTH];

        // Buffer write; contents are deliberately not reset.
        always_ff @(posedge clk) begin
            if (i_valid) begin
                mem[wp_reg] <= lane_in;
            end
        end

        // Registered read; holds its value on cycles without an output.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dout_reg <= '0;
            end else if (out_fire) begin
                dout_reg <= (delay_next == '0) ? lane_in : mem[rd_addr];
            end
        end

        assign o_data[gi*WIDTH +: WIDTH] = dout_reg;
    end

endmodule

// File: tb/tb_prog_delay_line.sv
// Testbench for prog_delay_line: two instances (MAX_DEPTH=8 and 6) driven
// by the same stream, checked against a history-based reference model and
// a directed vector table.
module tb_prog_delay_line;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_valid;
    logic [15:0] i_data;
    logic        i_delay_we;
    logic [3:0]  i_delay;

    logic        o_valid0, o_clamped0;
    logic [15:0] o_data0;
    logic        o_valid1, o_clamped1;
    logic [15:0] o_data1;
`ifdef PROG_DELAY_LINE_OCCUPANCY_EN
    logic [3:0]  o_fill0;
    logic [2:0]  o_fill1;
`endif

    always #5 clk = ~clk;

    prog_delay_line #(.WIDTH(8), .CHANNELS(2), .MAX_DEPTH(8), .RESET_DELAY(4)) u0 (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
        .i_delay_we(i_delay_we), .i_delay(i_delay),
        .o_valid(o_valid0), .o_data(o_data0), .o_clamped(o_clamped0)
`ifdef PROG_DELAY_LINE_OCCUPANCY_EN
        , .o_fill(o_fill0)
`endif
    );

    prog_delay_line #(.WIDTH(8), .CHANNELS(2), .MAX_DEPTH(6), .RESET_DELAY(4)) u6 (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
        .i_delay_we(i_delay_we), .i_delay(i_delay[2:0]),
        .o_valid(o_valid1), .o_data(o_data1), .o_clamped(o_clamped1)
`ifdef PROG_DELAY_LINE_OCCUPANCY_EN
        , .o_fill(o_fill1)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state, one slot per instance.
    // hist[k][j] is the sample accepted j+1 accepts ago.
    logic [15:0] hist [2][16];
    int          cnt   [2];
    int          dd    [2];
    int          maxd  [2];
    bit          clamp [2];
    bit          exp_v [2];
    logic [15:0] exp_d [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cnt[k]   = 0;
            dd[k]    = 4;
            clamp[k] = 1'b0;
            exp_v[k] = 1'b0;
            exp_d[k] = '0;
        end
    endtask

    // Output after this cycle = sample accepted D accepts earlier, provided
    // at least D samples were accepted since the last flush.
    task automatic model_step(input int k, input bit v, input bit we, input int dreq,
                              input logic [15:0] din);
        if (we) begin
            if (dreq > maxd[k]) begin
                dd[k]    = maxd[k];
                clamp[k] = 1'b1;
            end else begin
                dd[k] = dreq;
            end
            cnt[k] = 0;
        end
        exp_v[k] = 1'b0;
        if (v) begin
            if (cnt[k] >= dd[k]) begin
                exp_v[k] = 1'b1;
                exp_d[k] = (dd[k] == 0) ? din : hist[k][dd[k]-1];
            end
            for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = din;
            if (cnt[k] < 100) cnt[k]++;
        end
    endtask

    // One clock: drive at the falling edge, advance the model, check at the
    // next falling edge.
    task automatic cyc(input bit v, input bit we, input int dreq, input logic [15:0] din);
        i_valid    = v;
        i_delay_we = we;
        i_delay    = 4'(dreq);
        i_data     = din;
        model_step(0, v, we, dreq, din);
        model_step(1, v, we, dreq & 7, din);
        @(negedge clk);
        $display("txn v=%0d we=%0d d=%0d din=%h | u0 v=%0d d=%h c=%0d | u6 v=%0d d=%h c=%0d",
                 v, we, dreq, din, o_valid0, o_data0, o_clamped0, o_valid1, o_data1, o_clamped1);
        chk("u0_valid", 32'(o_valid0), 32'(exp_v[0]));
        chk("u0_data", 32'(o_data0), 32'(exp_d[0]));
        chk("u0_clamped", 32'(o_clamped0), 32'(clamp[0]));
        chk("u6_valid", 32'(o_valid1), 32'(exp_v[1]));
        chk("u6_data", 32'(o_data1), 32'(exp_d[1]));
        chk("u6_clamped", 32'(o_clamped1), 32'(clamp[1]));
`ifdef PROG_DELAY_LINE_OCCUPANCY_EN
        chk("u0_fill", 32'(o_fill0), 32'((cnt[0] < maxd[0]) ? cnt[0] : maxd[0]));
        chk("u6_fill", 32'(o_fill1), 32'((cnt[1] < maxd[1]) ? cnt[1] : maxd[1]));
`endif
    endtask

    typedef struct {
        bit       v;
        bit       we;
        int       d;
        logic [7:0] s;
        bit       ev;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [15:0] r;
        logic [7:0]  s;

        maxd[0] = 8;
        maxd[1] = 6;
        model_reset();
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 16; j++) hist[k][j] = '0;

        // D=4 from reset, continuous stream, then toggling valid, then a
        // reload to D=2 together with an accept.
        tbl[0]  = '{1'b1, 1'b0, 0, 8'd1,  1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 0, 8'd2,  1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 0, 8'd3,  1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 0, 8'd4,  1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 0, 8'd5,  1'b1, 8'd1};
        tbl[5]  = '{1'b1, 1'b0, 0, 8'd6,  1'b1, 8'd2};
        tbl[6]  = '{1'b1, 1'b0, 0, 8'd7,  1'b1, 8'd3};
        tbl[7]  = '{1'b0, 1'b0, 0, 8'd8,  1'b0, 8'd3};
        tbl[8]  = '{1'b1, 1'b0, 0, 8'd8,  1'b1, 8'd4};
        tbl[9]  = '{1'b0, 1'b0, 0, 8'd9,  1'b0, 8'd4};
        tbl[10] = '{1'b1, 1'b0, 0, 8'd9,  1'b1, 8'd5};
        tbl[11] = '{1'b1, 1'b1, 2, 8'd10, 1'b0, 8'd5};
        tbl[12] = '{1'b1, 1'b0, 0, 8'd11, 1'b0, 8'd5};
        tbl[13] = '{1'b1, 1'b0, 0, 8'd12, 1'b1, 8'd10};
        tbl[14] = '{1'b1, 1'b0, 0, 8'd13, 1'b1, 8'd11};

        reset_n    = 1'b0;
        i_valid    = 1'b0;
        i_delay_we = 1'b0;
        i_delay    = '0;
        i_data     = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(o_valid0), 32'd0);
        chk("rst_data", 32'(o_data0), 32'd0);
        chk("rst_clamped", 32'(o_clamped0), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].v, tbl[i].we, tbl[i].d, {tbl[i].s, tbl[i].s});
            chk("tbl_valid", 32'(o_valid0), 32'(tbl[i].ev));
            chk("tbl_data", 32'(o_data0), 32'({tbl[i].ed, tbl[i].ed}));
        end

        // Clamp: request 12 on MAX_DEPTH=8; the 9th accept returns the load sample.
        for (int i = 0; i < 9; i++) begin
            s = 8'(20 + i);
            cyc(1'b1, i == 0, 12, {s, ~s});
            if (i == 0) chk("clamp_set", 32'(o_clamped0), 32'd1);
        end
        chk("clamp_out_valid", 32'(o_valid0), 32'd1);
        chk("clamp_out_data", 32'(o_data0), 32'({8'd20, ~8'd20}));

        // Request 7: clamps on the depth-6 instance and wraps its pointer.
        for (int i = 0; i < 16; i++) begin
            r = 16'($urandom);
            cyc(1'b1, i == 0, 7, r);
        end
        chk("clamp6_sticky", 32'(o_clamped1), 32'd1);
        chk("clamp8_sticky", 32'(o_clamped0), 32'd1);

        // D=0: registered pass-through.
        r = 16'($urandom);
        cyc(1'b1, 1'b1, 0, r);
        chk("d0_pass", 32'(o_data0), 32'(r));
        for (int i = 0; i < 10; i++) begin
            r = 16'($urandom);
            cyc(($urandom % 2) == 1, 1'b0, 0, r);
        end

        // Reset asserted mid-RUN, between clock edges.
        cyc(1'b1, 1'b1, 4, 16'h0101);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 0, 16'(16'h1111 * (i + 2)));
        #2;
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_delay_we = 1'b0;
        #1;
        chk("async_valid0", 32'(o_valid0), 32'd0);
        chk("async_data0", 32'(o_data0), 32'd0);
        chk("async_clamped0", 32'(o_clamped0), 32'd0);
        chk("async_valid1", 32'(o_valid1), 32'd0);
        chk("async_data1", 32'(o_data1), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 0, 16'(16'hA0A0 + i));
        chk("post_rst_first", 32'(o_valid0), 32'd1);
        chk("post_rst_data", 32'(o_data0), 32'h A0A0);

        // Randomized traffic with occasional reloads.
        for (int i = 0; i < 400; i++) begin
            r = 16'($urandom);
            cyc(($urandom % 4) != 0, ($urandom % 20) == 0, int'($urandom % 16), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
